// File: rtl/control_pkg.sv
// control_pkg: shared decode constants for the MIPS-subset pipeline.
//   - opcode (Opcode, instr[31:26]) and funct (Function, instr[5:0]) values
//   - ALU_Op codes (bit 3 reserved, always 0)
//   - bit positions of the 12-bit pipeline control word carried through
//     ID/EX, EX/MEM and MEM/WB: [11:8] ALU_Op, 7 RegWrite, 6 RegRead,
//     5 RegDst, 4 ALUsrc, 3 MemWrite, 2 MemRead, 1 MemtoReg, 0 Muxif
//   - make_cw(): builds a control word from an 8-bit flag row and ALU_Op
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int CW_WIDTH     = 12;
  localparam int CW_ALU_HI    = 11;
  localparam int CW_ALU_LO    = 8;
  localparam int CW_REG_WRITE = 7;
  localparam int CW_REG_READ  = 6;
  localparam int CW_REG_DST   = 5;
  localparam int CW_ALU_SRC   = 4;
  localparam int CW_MEM_WRITE = 3;
  localparam int CW_MEM_READ  = 2;
  localparam int CW_MEM_TO_REG = 1;
  localparam int CW_MUXIF     = 0;

  // flags is the row RegWrite,RegRead,RegDst,ALUsrc,MemWrite,MemRead,
  // MemtoReg,Muxif (MSB first), which lines up with word bits [7:0].
  function automatic logic [CW_WIDTH-1:0] make_cw(input logic [7:0] flags,
                                                  input logic [3:0] alu);
    return {alu, flags};
  endfunction

endpackage

// File: rtl/control_alu_funct_decode.sv
// alu_funct_decode: maps the R-type funct field to an ALU_Op.
//   Function  in  6  instruction bits [5:0]
//   alu_op    out 4  ALU operation for the supported functs
//   legal     out 1  1 = Function is a supported R-type operation
module alu_funct_decode
  import control_pkg::*;
(
  input  logic [5:0] Function,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    alu_op = ALU_AND;
    legal  = 1'b0;
    case (Function)
      FN_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
      FN_AND: begin alu_op = ALU_AND; legal = 1'b1; end
      FN_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
      FN_SLT: begin alu_op = ALU_SLT; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control.sv
// control: main decode unit of the 5-stage MIPS-subset pipeline.
// Purely combinational decode of Opcode/Function into the datapath control
// signals; reset forces every output to 0 combinationally.
//   clk, reset              clock / synchronous active-high reset (clk only
//                           used by the optional illegal flag)
//   Opcode, Function        instruction bits [31:26] and [5:0]
//   RegWrite, RegRead, ALU_Op[3:0], RegDst, ALUsrc, MemWrite, MemRead,
//   MemtoReg, Muxif         control outputs
// Optional: define CONTROL_ILLEGAL_DETECT_EN to add illegal_sticky, set on
// any clock edge (reset low) where a non-zero instruction decodes as NOP,
// and held until reset.
module control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function,
  output logic       RegWrite,
  output logic       RegRead,
  output logic [3:0] ALU_Op,
  output logic       RegDst,
  output logic       ALUsrc,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       Muxif
`ifdef CONTROL_ILLEGAL_DETECT_EN
  ,
  output logic       illegal_sticky
`endif
);

  logic [3:0]          fn_alu;
  logic                fn_legal;
  logic [CW_WIDTH-1:0] dec_word;
  logic [CW_WIDTH-1:0] word;

  alu_funct_decode u_alu_funct_decode (
    .Function (Function),
    .alu_op   (fn_alu),
    .legal    (fn_legal)
  );

  always_comb begin
    dec_word = '0;
    case (Opcode)
      OP_RTYPE: if (fn_legal) dec_word = make_cw(8'b1110_0000, fn_alu);
      OP_LW:    dec_word = make_cw(8'b1101_0110, ALU_ADD);
      OP_SW:    dec_word = make_cw(8'b0101_1000, ALU_ADD);
      OP_BEQ:   dec_word = make_cw(8'b0100_0001, ALU_SUB);
      OP_ADDI:  dec_word = make_cw(8'b1101_0000, ALU_ADD);
      OP_SLTI:  dec_word = make_cw(8'b1101_0000, ALU_SLT);
      OP_ANDI:  dec_word = make_cw(8'b1101_0000, ALU_AND);
      OP_ORI:   dec_word = make_cw(8'b1101_0000, ALU_OR);
      OP_J:     dec_word = make_cw(8'b0000_0001, ALU_AND);
      default:  dec_word = '0;
    endcase
  end

  assign word     = reset ? '0 : dec_word;

  assign ALU_Op   = word[CW_ALU_HI:CW_ALU_LO];
  assign RegWrite = word[CW_REG_WRITE];
  assign RegRead  = word[CW_REG_READ];
  assign RegDst   = word[CW_REG_DST];
  assign ALUsrc   = word[CW_ALU_SRC];
  assign MemWrite = word[CW_MEM_WRITE];
  assign MemRead  = word[CW_MEM_READ];
  assign MemtoReg = word[CW_MEM_TO_REG];
  assign Muxif    = word[CW_MUXIF];

`ifdef CONTROL_ILLEGAL_DETECT_EN
  // The all-zero word is a pipeline bubble, not an illegal instruction.
  logic illegal_now;
  assign illegal_now = ({Opcode, Function} != 12'h000) && (dec_word == '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset)            illegal_sticky <= 1'b0;
    else if (illegal_now) illegal_sticky <= 1'b1;
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
`endif

endmodule

// File: tb/tb_control.sv
// tb_control: self-checking bench for control. Directed test-plan vectors
// followed by random Opcode/Function/reset, compared against a table-driven
// reference built directly from the instruction rows.
module tb_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Function;
  logic       RegWrite, RegRead, RegDst, ALUsrc, MemWrite, MemRead, MemtoReg, Muxif;
  logic [3:0] ALU_Op;
`ifdef CONTROL_ILLEGAL_DETECT_EN
  logic       illegal_sticky;
  logic       exp_sticky = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .Function (Function),
    .RegWrite (RegWrite),
    .RegRead  (RegRead),
    .ALU_Op   (ALU_Op),
    .RegDst   (RegDst),
    .ALUsrc   (ALUsrc),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .MemtoReg (MemtoReg),
    .Muxif    (Muxif)
`ifdef CONTROL_ILLEGAL_DETECT_EN
    ,
    .illegal_sticky (illegal_sticky)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] row;   // RegWrite,RegRead,RegDst,ALUsrc,MemWrite,MemRead,MemtoReg,Muxif
    logic [3:0] alu;
  } exp_t;

  // Reference rows transcribed from the instruction table.
  function automatic exp_t ref_model(input logic r, input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e.row = 8'b0;
    e.alu = 4'd0;
    if (r) return e;
    if (op == 6'h00) begin
      e.row = 8'b1110_0000;
      if      (fn == 6'h20) e.alu = 4'd2;
      else if (fn == 6'h22) e.alu = 4'd6;
      else if (fn == 6'h24) e.alu = 4'd0;
      else if (fn == 6'h25) e.alu = 4'd1;
      else if (fn == 6'h2A) e.alu = 4'd7;
      else e.row = 8'b0;
    end
    else if (op == 6'h23) begin e.row = 8'b1101_0110; e.alu = 4'd2; end
    else if (op == 6'h2B) begin e.row = 8'b0101_1000; e.alu = 4'd2; end
    else if (op == 6'h04) begin e.row = 8'b0100_0001; e.alu = 4'd6; end
    else if (op == 6'h08) begin e.row = 8'b1101_0000; e.alu = 4'd2; end
    else if (op == 6'h0A) begin e.row = 8'b1101_0000; e.alu = 4'd7; end
    else if (op == 6'h0C) begin e.row = 8'b1101_0000; e.alu = 4'd0; end
    else if (op == 6'h0D) begin e.row = 8'b1101_0000; e.alu = 4'd1; end
    else if (op == 6'h02) begin e.row = 8'b0000_0001; e.alu = 4'd0; end
    return e;
  endfunction

  // Apply one vector, check the combinational outputs, then clock it and
  // check the optional sticky flag.
  task automatic apply(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    logic [11:0] got;
    @(negedge clk);
    reset    = r;
    Opcode   = op;
    Function = fn;
    #1;
    e   = ref_model(r, op, fn);
    got = {RegWrite, RegRead, RegDst, ALUsrc, MemWrite, MemRead, MemtoReg, Muxif, ALU_Op};
    check(tag, {20'd0, got}, {20'd0, e.row, e.alu});
    if (MemRead && MemWrite) check({tag, "_memrw_excl"}, 32'd1, 32'd0);
    if (RegWrite && MemWrite) check({tag, "_rw_mw_excl"}, 32'd1, 32'd0);
    @(posedge clk);
`ifdef CONTROL_ILLEGAL_DETECT_EN
    if (r) exp_sticky = 1'b0;
    else if ({op, fn} != 12'h000 && ref_model(1'b0, op, fn).row == 8'b0) exp_sticky = 1'b1;
    #1;
    check({tag, "_sticky"}, {31'd0, illegal_sticky}, {31'd0, exp_sticky});
`endif
  endtask

  logic [5:0] legal_ops[9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
  logic [5:0] legal_fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    reset = 1'b1; Opcode = 6'h00; Function = 6'h00;
    apply("reset_lw",  1'b1, 6'h23, 6'h00);
    apply("lw",        1'b0, 6'h23, 6'h00);
    apply("r_add",     1'b0, 6'h00, 6'h20);
    apply("r_sub",     1'b0, 6'h00, 6'h22);
    apply("r_and",     1'b0, 6'h00, 6'h24);
    apply("r_or",      1'b0, 6'h00, 6'h25);
    apply("r_slt",     1'b0, 6'h00, 6'h2A);
    apply("sw",        1'b0, 6'h2B, 6'h11);
    apply("beq",       1'b0, 6'h04, 6'h3F);
    apply("j",         1'b0, 6'h02, 6'h00);
    apply("bubble",    1'b0, 6'h00, 6'h00);
    apply("addi",      1'b0, 6'h08, 6'h05);
    apply("slti",      1'b0, 6'h0A, 6'h00);
    apply("andi",      1'b0, 6'h0C, 6'h20);
    apply("ori",       1'b0, 6'h0D, 6'h00);
    apply("op_3f",     1'b0, 6'h3F, 6'h00);
    apply("after_3f",  1'b0, 6'h23, 6'h00);
    apply("r_fn07",    1'b0, 6'h00, 6'h07);
    apply("reset_clr", 1'b1, 6'h3F, 6'h00);
    apply("post_rst",  1'b0, 6'h00, 6'h00);

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [5:0] op, fn;
      r  = ($urandom_range(0, 19) == 0);
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 8)] : 6'($urandom);
      fn = ($urandom_range(0, 2) != 0) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
      apply("rand", r, op, fn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
